i2c_mem_subsystem: RTL and testbench

- Self-contained I2C-style memory subsystem. A master FSM serialises one transaction over an internal two-wire link (scl/sda) to a 128x8 memory slave.
- Write data is first conditioned by an 8-bit universal shift unit selected by S.
- Driven from the shared bus interface. Exposes read data and a one-cycle Done pulse.

---
 rtl/i2c_mem_pkg.sv | 30 +++
 rtl/i2c_mem_slave.sv | 83 ++++++++
 rtl/i2c_mem_subsystem.sv | 158 +++++++++++++++
 tb/tb_i2c_mem_subsystem.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_mem_pkg.sv
// rtl/i2c_mem_pkg.sv - shared widths, FSM states and shift-op encodings
package i2c_mem_pkg;

    localparam int ADDR_WIDTH = 7;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_RW,
        ST_ACK1,
        ST_DATA,
        ST_ACK2,
        ST_STOP,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        SH_LOAD = 3'b000,
        SH_SHR  = 3'b001,
        SH_SHL  = 3'b010,
        SH_ROR  = 3'b011,
        SH_ROL  = 3'b100,
        SH_INV  = 3'b101,
        SH_CLR  = 3'b110,
        SH_SET  = 3'b111
    } shift_op_t;

endpackage

// File: rtl/i2c_mem_slave.sv
// rtl/i2c_mem_slave.sv - two-wire memory slave; frames and decodes purely from scl/sda
module i2c_mem_slave #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic sda_drive
);
    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    localparam int SW      = $clog2(ADDR_WIDTH + DATA_WIDTH + 3);
    localparam int DW_BITS = $clog2(DATA_WIDTH);

    // Bit slots after START: address, rw, ack1, data, ack2.
    localparam logic [SW-1:0] RW_SLOT    = SW'(ADDR_WIDTH);
    localparam logic [SW-1:0] ACK1_SLOT  = SW'(ADDR_WIDTH + 1);
    localparam logic [SW-1:0] DATA_FIRST = SW'(ADDR_WIDTH + 2);
    localparam logic [SW-1:0] ACK2_SLOT  = SW'(ADDR_WIDTH + 2 + DATA_WIDTH);
    localparam logic [SW-1:0] DATA_LAST  = SW'(ADDR_WIDTH + 1 + DATA_WIDTH);

    logic [DATA_WIDTH-1:0] memory [0:DEPTH-1];
    logic                  active;
    logic                  sda_prev;
    logic                  rw;
    logic [SW-1:0]         slot;
    logic [ADDR_WIDTH-1:0] addr_sr;
    logic [DATA_WIDTH-1:0] data_sr;
    logic                  start_cond;
    logic                  in_data;
    logic [DW_BITS-1:0]    data_idx;

    // scl low marks a bit slot; sda falling with scl high is the only START.
    assign start_cond = scl && !sda && sda_prev;
    assign in_data    = active && (slot >= DATA_FIRST) && (slot < ACK2_SLOT);
    assign data_idx   = DW_BITS'(DATA_LAST - slot);

    always_comb begin
        sda_drive = 1'b1;
        if (active) begin
            if (slot == ACK1_SLOT)
                sda_drive = 1'b0;
            else if (in_data && !rw)
                sda_drive = memory[addr_sr][data_idx];
            else if (slot == ACK2_SLOT && rw)
                sda_drive = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active   <= 1'b0;
            sda_prev <= 1'b1;
            rw       <= 1'b0;
            slot     <= '0;
            addr_sr  <= '0;
            data_sr  <= '0;
            for (int i = 0; i < DEPTH; i++)
                memory[i] <= '0;
        end else begin
            sda_prev <= sda;
            if (start_cond) begin
                active <= 1'b1;
                slot   <= '0;
            end else if (active && !scl) begin
                slot <= slot + 1'b1;
                if (slot < RW_SLOT)
                    addr_sr <= {addr_sr[ADDR_WIDTH-2:0], sda};
                else if (slot == RW_SLOT)
                    rw <= sda;
                else if (in_data)
                    data_sr <= {data_sr[DATA_WIDTH-2:0], sda};
                else if (slot == ACK2_SLOT) begin
                    if (rw)
                        memory[addr_sr] <= data_sr;
                    active <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/i2c_mem_subsystem.sv
// rtl/i2c_mem_subsystem.sv - master FSM and shift unit driving the two-wire memory slave
module i2c_mem_subsystem #(
    parameter int ADDR_WIDTH = i2c_mem_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = i2c_mem_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  M_en,
    input  logic                  R_W,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic [DATA_WIDTH-1:0] F_In,
    input  logic [2:0]            S,
    input  logic                  MSBIn,
    input  logic                  LSBIn,
    output logic [DATA_WIDTH-1:0] Data_Out,
    output logic                  Done,
    output logic                  Busy
);
    import i2c_mem_pkg::*;

    localparam int IW = $clog2(DATA_WIDTH);

    state_t                state, next_state;
    logic                  launch;
    logic [IW-1:0]         bit_idx;
    logic                  rw_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic [DATA_WIDTH-1:0] rdata_sr;
    logic                  scl, sda, sda_m, sda_s;

    always_comb begin
        wdata_next = F_In;
        case (shift_op_t'(S))
            SH_LOAD: wdata_next = F_In;
            SH_SHR:  wdata_next = {MSBIn, F_In[DATA_WIDTH-1:1]};
            SH_SHL:  wdata_next = {F_In[DATA_WIDTH-2:0], LSBIn};
            SH_ROR:  wdata_next = {F_In[0], F_In[DATA_WIDTH-1:1]};
            SH_ROL:  wdata_next = {F_In[DATA_WIDTH-2:0], F_In[DATA_WIDTH-1]};
            SH_INV:  wdata_next = ~F_In;
            SH_CLR:  wdata_next = '0;
            SH_SET:  wdata_next = '1;
            default: wdata_next = F_In;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // DONE accepts a new launch so held M_en gives back-to-back transactions.
    always_comb begin
        next_state = state;
        launch     = 1'b0;
        scl        = 1'b1;
        sda_m      = 1'b1;
        case (state)
            ST_IDLE: begin
                if (M_en) begin
                    launch     = 1'b1;
                    next_state = ST_START;
                end
            end
            ST_START: begin
                sda_m      = 1'b0;
                next_state = ST_ADDR;
            end
            ST_ADDR: begin
                scl   = 1'b0;
                sda_m = addr_q[bit_idx];
                if (bit_idx == '0)
                    next_state = ST_RW;
            end
            ST_RW: begin
                scl        = 1'b0;
                sda_m      = rw_q;
                next_state = ST_ACK1;
            end
            ST_ACK1: begin
                scl        = 1'b0;
                next_state = ST_DATA;
            end
            ST_DATA: begin
                scl   = 1'b0;
                sda_m = rw_q ? wdata_q[bit_idx] : 1'b1;
                if (bit_idx == '0)
                    next_state = ST_ACK2;
            end
            ST_ACK2: begin
                scl        = 1'b0;
                sda_m      = rw_q;
                next_state = ST_STOP;
            end
            ST_STOP: next_state = ST_DONE;
            ST_DONE: begin
                if (M_en) begin
                    launch     = 1'b1;
                    next_state = ST_START;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_idx  <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_sr <= '0;
            Data_Out <= '0;
        end else begin
            if (launch) begin
                rw_q    <= R_W;
                addr_q  <= ADDR;
                wdata_q <= wdata_next;
            end
            case (state)
                ST_START: bit_idx <= IW'(ADDR_WIDTH - 1);
                ST_ADDR:  bit_idx <= bit_idx - 1'b1;
                ST_ACK1:  bit_idx <= IW'(DATA_WIDTH - 1);
                ST_DATA: begin
                    bit_idx  <= bit_idx - 1'b1;
                    rdata_sr <= {rdata_sr[DATA_WIDTH-2:0], sda};
                end
                ST_ACK2: begin
                    if (!rw_q)
                        Data_Out <= rdata_sr;
                end
                default: ;
            endcase
        end
    end

    // Open-drain bus: either side pulls low, released is 1.
    assign sda  = sda_m & sda_s;
    assign Done = (state == ST_DONE);
    assign Busy = (state inside {ST_START, ST_ADDR, ST_RW, ST_ACK1, ST_DATA, ST_ACK2, ST_STOP});

    i2c_mem_slave #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) M0 (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda      (sda),
        .sda_drive(sda_s)
    );

endmodule

// File: tb/tb_i2c_mem_subsystem.sv
// tb/tb_i2c_mem_subsystem.sv - scoreboard bench for i2c_mem_subsystem
module tb_i2c_mem_subsystem;

    logic       clk = 1'b0;
    logic       reset;
    logic       M_en;
    logic       R_W;
    logic [6:0] ADDR;
    logic [7:0] F_In;
    logic [2:0] S;
    logic       MSBIn;
    logic       LSBIn;
    logic [7:0] Data_Out;
    logic       Done;
    logic       Busy;

    int vec_cnt     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        logic [7:0] data;
        int         launch;
    } exp_t;

    exp_t       sb[$];
    int         done_cyc[$];
    logic [7:0] model_mem [0:127];
    logic [7:0] last_read;

    i2c_mem_subsystem dut (
        .clk     (clk),
        .reset   (reset),
        .M_en    (M_en),
        .R_W     (R_W),
        .ADDR    (ADDR),
        .F_In    (F_In),
        .S       (S),
        .MSBIn   (MSBIn),
        .LSBIn   (LSBIn),
        .Data_Out(Data_Out),
        .Done    (Done),
        .Busy    (Busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] shift_ref(input logic [2:0] s, input logic [7:0] d,
                                             input logic msb, input logic lsb);
        case (s)
            3'b000:  return d;
            3'b001:  return {msb, d[7:1]};
            3'b010:  return {d[6:0], lsb};
            3'b011:  return {d[0], d[7:1]};
            3'b100:  return {d[6:0], d[7]};
            3'b101:  return ~d;
            3'b110:  return 8'h00;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic push_expect(input logic rw, input logic [6:0] a, input logic [7:0] w);
        exp_t e;
        e.launch = cyc;
        if (rw) begin
            model_mem[a] = w;
        end else begin
            last_read = model_mem[a];
        end
        e.data = last_read;
        sb.push_back(e);
    endtask

    task automatic launch(input logic rw, input logic [6:0] a, input logic [7:0] f,
                          input logic [2:0] s, input logic msb, input logic lsb);
        @(negedge clk);
        R_W = rw; ADDR = a; F_In = f; S = s; MSBIn = msb; LSBIn = lsb; M_en = 1'b1;
        @(posedge clk);
        #1;
        push_expect(rw, a, shift_ref(s, f, msb, lsb));
        @(negedge clk);
        M_en = 1'b0;
        check("busy_after_launch", Busy, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        sb.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] f, input logic [2:0] s,
                      input logic msb, input logic lsb);
        launch(1'b1, a, f, s, msb, lsb);
        wait_drain();
    endtask

    task automatic rd_expect(input string tag, input logic [6:0] a, input logic [7:0] lit);
        launch(1'b0, a, 8'h00, 3'b000, 1'b0, 1'b0);
        wait_drain();
        check(tag, Data_Out, lit);
    endtask

    // Every Done pulse must match the oldest outstanding launch.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && Done) begin
            done_cyc.push_back(cyc);
            check("busy_at_done", Busy, 0);
            check("sb_nonempty_at_done", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("latency", cyc - e.launch + 1, 21);
                check("data_out", Data_Out, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; M_en = 1'b0; R_W = 1'b0; ADDR = '0; F_In = '0; S = '0;
        MSBIn = 1'b0; LSBIn = 1'b0; last_read = '0;
        for (int i = 0; i < 128; i++) model_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", Data_Out, 0);
        check("rst_done", Done, 0);
        check("rst_busy", Busy, 0);
        @(negedge clk);
        reset = 1'b0;

        wr(7'd120, 8'd120, 3'b000, 1'b0, 1'b0);
        rd_expect("rd_120", 7'd120, 8'd120);
        rd_expect("rd_100", 7'd100, 8'h00);

        wr(7'd5, 8'h78, 3'b001, 1'b1, 1'b0);
        rd_expect("rd_5_shr", 7'd5, 8'hBC);
        wr(7'd6, 8'h78, 3'b010, 1'b0, 1'b1);
        rd_expect("rd_6_shl", 7'd6, 8'hF1);

        wr(7'd127, 8'hA5, 3'b000, 1'b0, 1'b0);
        rd_expect("rd_127", 7'd127, 8'hA5);
        rd_expect("rd_0", 7'd0, 8'h00);

        for (int i = 0; i < 5; i++)
            wr(7'(20 + i), 8'h81, 3'(3 + i), 1'b0, 1'b0);
        rd_expect("rd_ror", 7'd20, 8'hC0);
        rd_expect("rd_rol", 7'd21, 8'h03);
        rd_expect("rd_inv", 7'd22, 8'h7E);
        rd_expect("rd_clr", 7'd23, 8'h00);
        rd_expect("rd_set", 7'd24, 8'hFF);

        // Abort a write ten cycles in.
        launch(1'b1, 7'd9, 8'h55, 3'b000, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        check("abort_data_out", Data_Out, 0);
        sb.delete();
        done_cyc.delete();
        last_read = '0;
        for (int i = 0; i < 128; i++) model_mem[i] = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(posedge clk);
        check("abort_no_done", done_cyc.size(), 0);
        rd_expect("rd_9_aborted", 7'd9, 8'h00);

        // Held M_en: two back-to-back reads.
        wr(7'd50, 8'h3C, 3'b000, 1'b0, 1'b0);
        done_cyc.delete();
        @(negedge clk);
        R_W = 1'b0; ADDR = 7'd50; F_In = '0; S = '0; M_en = 1'b1;
        @(posedge clk);
        #1;
        push_expect(1'b0, 7'd50, 8'h00);
        repeat (21) @(posedge clk);
        #1;
        push_expect(1'b0, 7'd50, 8'h00);
        @(negedge clk);
        M_en = 1'b0;
        wait_drain();
        check("b2b_pulses", done_cyc.size(), 2);
        if (done_cyc.size() == 2)
            check("b2b_spacing", done_cyc[1] - done_cyc[0], 21);
        check("b2b_data", Data_Out, 8'h3C);

        // M_en toggling while Busy must not restart.
        done_cyc.delete();
        launch(1'b1, 7'd51, 8'h66, 3'b000, 1'b0, 1'b0);
        repeat (12) @(negedge clk) M_en = ~M_en;
        M_en = 1'b0;
        wait_drain();
        repeat (5) @(posedge clk);
        check("toggle_pulses", done_cyc.size(), 1);
        rd_expect("rd_51", 7'd51, 8'h66);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
